// File: rtl/pc_state_reg.sv
// Y86 SEQ PC state register: latches the committed next PC, owns the processor
// status and BOOT/RUN/STOP sequencing, and keeps retired-instruction/cycle counters.
module pc_state_reg #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [63:0] MEM_SIZE = 64'h1000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [63:0]      updated_pc,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             dmem_error,
  input  logic             stall,
  output logic [63:0]      pc,
  output logic [63:0]      pc_prev,
  output logic [2:0]       stat,
  output logic             running,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] ICODE_HALT = 4'h0;

  state_t state;

  // NOTE: all state lives in one clocked block written with non-blocking
  // assignments, so every output is a flop and pc_prev <= pc sees the old pc.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      pc_prev     <= RESET_PC;
      stat        <= STAT_AOK;
      running     <= 1'b0;
      instr_count <= '0;
      cycle_count <= '0;
    end else begin
      unique case (state)
        BOOT: begin
          state   <= RUN;
          running <= 1'b1;
        end

        RUN: begin
          cycle_count <= cycle_count + CNT_W'(1);
          if (!stall) begin
            // Faults and halt leave pc on the offending instruction.
            if (imem_error) begin
              stat    <= STAT_ADR;
              state   <= STOP;
              running <= 1'b0;
            end else if (!instr_valid) begin
              stat    <= STAT_INS;
              state   <= STOP;
              running <= 1'b0;
            end else if (dmem_error) begin
              stat    <= STAT_ADR;
              state   <= STOP;
              running <= 1'b0;
            end else if (icode == ICODE_HALT) begin
              stat    <= STAT_HLT;
              state   <= STOP;
              running <= 1'b0;
            end else if (updated_pc >= MEM_SIZE) begin
              stat    <= STAT_ADR;
              state   <= STOP;
              running <= 1'b0;
            end else begin
              pc          <= updated_pc;
              pc_prev     <= pc;
              instr_count <= instr_count + CNT_W'(1);
              stat        <= STAT_AOK;
            end
          end
        end

        STOP: begin
          // Frozen until reset.
          state   <= STOP;
          running <= 1'b0;
        end

        default: begin
          state   <= BOOT;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_state_reg.sv
// Scoreboard bench for pc_state_reg: directed steps push hand-computed expected
// register values; a monitor on the falling edge pops and compares them.
module tb_pc_state_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] updated_pc;
  logic [3:0]  icode;
  logic        instr_valid, imem_error, dmem_error, stall;

  logic [63:0] pc, pc_prev, pc4, pc_prev4;
  logic [2:0]  stat, stat4;
  logic        running, running4;
  logic [31:0] instr_count, cycle_count;
  logic [3:0]  instr_count4, cycle_count4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_state_reg #(.RESET_PC(64'h0), .MEM_SIZE(64'h1000), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .updated_pc(updated_pc), .icode(icode),
    .instr_valid(instr_valid), .imem_error(imem_error), .dmem_error(dmem_error),
    .stall(stall), .pc(pc), .pc_prev(pc_prev), .stat(stat), .running(running),
    .instr_count(instr_count), .cycle_count(cycle_count)
  );

  // Narrow-counter copy, driven identically, used to observe counter wrap.
  pc_state_reg #(.RESET_PC(64'h0), .MEM_SIZE(64'h1000), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .updated_pc(updated_pc), .icode(icode),
    .instr_valid(instr_valid), .imem_error(imem_error), .dmem_error(dmem_error),
    .stall(stall), .pc(pc4), .pc_prev(pc_prev4), .stat(stat4), .running(running4),
    .instr_count(instr_count4), .cycle_count(cycle_count4)
  );

  typedef struct {
    string       name;
    logic [63:0] pc;
    logic [63:0] pc_prev;
    logic [2:0]  stat;
    logic        running;
    logic [31:0] ic;
    logic [31:0] cc;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: registered outputs are stable on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".pc"},      pc,           e.pc);
        check({e.name, ".pc_prev"}, pc_prev,      e.pc_prev);
        check({e.name, ".stat"},    64'(stat),    64'(e.stat));
        check({e.name, ".running"}, 64'(running), 64'(e.running));
        check({e.name, ".icount"},  64'(instr_count), 64'(e.ic));
        check({e.name, ".ccount"},  64'(cycle_count), 64'(e.cc));
        check({e.name, ".icount4"}, 64'(instr_count4), 64'(e.ic[3:0]));
        check({e.name, ".ccount4"}, 64'(cycle_count4), 64'(e.cc[3:0]));
        check({e.name, ".stat4"},   64'(stat4),   64'(e.stat));
      end
    end
  end

  // Drive one cycle of inputs, let the edge happen, then post the expected state.
  task automatic step(input string name, input logic rst_i, input logic st_i,
                      input logic [63:0] upc_i, input logic [3:0] icode_i,
                      input logic iv_i, input logic ime_i, input logic dme_i,
                      input logic [63:0] e_pc, input logic [63:0] e_prev,
                      input logic [2:0] e_stat, input logic e_run,
                      input logic [31:0] e_ic, input logic [31:0] e_cc);
    exp_t e;
    @(negedge clk);
    reset       = rst_i;
    stall       = st_i;
    updated_pc  = upc_i;
    icode       = icode_i;
    instr_valid = iv_i;
    imem_error  = ime_i;
    dmem_error  = dme_i;
    @(posedge clk);
    #1;
    e.name = name; e.pc = e_pc; e.pc_prev = e_prev; e.stat = e_stat;
    e.running = e_run; e.ic = e_ic; e.cc = e_cc;
    sb.push_back(e);
  endtask

  // Plain nop commit-style inputs with no faults.
  task automatic nop(input string name, input logic st_i, input logic [63:0] upc_i,
                     input logic [63:0] e_pc, input logic [63:0] e_prev,
                     input logic [2:0] e_stat, input logic e_run,
                     input logic [31:0] e_ic, input logic [31:0] e_cc);
    step(name, 1'b0, st_i, upc_i, 4'h1, 1'b1, 1'b0, 1'b0,
         e_pc, e_prev, e_stat, e_run, e_ic, e_cc);
  endtask

  task automatic do_reset(input string name);
    step(name, 1'b1, 1'b0, 64'h0, 4'h1, 1'b1, 1'b0, 1'b0,
         64'h0, 64'h0, 3'd1, 1'b0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; updated_pc = '0; icode = 4'h1;
    instr_valid = 1'b1; imem_error = 1'b0; dmem_error = 1'b0;

    // Sequential nops from reset.
    do_reset("rst0");
    nop("boot",  1'b0, 64'h1,   64'h0,   64'h0,  3'd1, 1'b1, 0, 0);
    nop("nop1",  1'b0, 64'h1,   64'h1,   64'h0,  3'd1, 1'b1, 1, 1);
    nop("nop2",  1'b0, 64'h2,   64'h2,   64'h1,  3'd1, 1'b1, 2, 2);
    nop("nop3",  1'b0, 64'h3,   64'h3,   64'h2,  3'd1, 1'b1, 3, 3);
    // Stall holds pc, counts cycles only.
    nop("to10",  1'b0, 64'h10,  64'h10,  64'h3,  3'd1, 1'b1, 4, 4);
    nop("stl1",  1'b1, 64'h99,  64'h10,  64'h3,  3'd1, 1'b1, 4, 5);
    nop("stl2",  1'b1, 64'h99,  64'h10,  64'h3,  3'd1, 1'b1, 4, 6);
    nop("to20",  1'b0, 64'h20,  64'h20,  64'h10, 3'd1, 1'b1, 5, 7);
    nop("self",  1'b0, 64'h20,  64'h20,  64'h20, 3'd1, 1'b1, 6, 8);
    // Memory-size boundary.
    nop("fff",   1'b0, 64'hFFF,  64'hFFF, 64'h20, 3'd1, 1'b1, 7, 9);
    nop("1000",  1'b0, 64'h1000, 64'hFFF, 64'h20, 3'd3, 1'b0, 7, 10);
    nop("frzA",  1'b0, 64'h5,    64'hFFF, 64'h20, 3'd3, 1'b0, 7, 10);
    nop("frzB",  1'b1, 64'h6,    64'hFFF, 64'h20, 3'd3, 1'b0, 7, 10);

    // Halt at 0x30, then frozen for 5 cycles.
    do_reset("rst1");
    nop("boot1", 1'b0, 64'h30,  64'h0,   64'h0,  3'd1, 1'b1, 0, 0);
    nop("to30",  1'b0, 64'h30,  64'h30,  64'h0,  3'd1, 1'b1, 1, 1);
    step("halt", 1'b0, 1'b0, 64'h31, 4'h0, 1'b1, 1'b0, 1'b0,
         64'h30, 64'h0, 3'd2, 1'b0, 1, 2);
    for (int i = 0; i < 5; i++)
      nop("hfrz", i[0], 64'h40, 64'h30, 64'h0, 3'd2, 1'b0, 1, 2);

    // imem_error beats invalid instruction and dmem_error.
    do_reset("rst2");
    nop("boot2", 1'b0, 64'h1,   64'h0,   64'h0,  3'd1, 1'b1, 0, 0);
    step("pri1", 1'b0, 1'b0, 64'h1, 4'h1, 1'b0, 1'b1, 1'b1,
         64'h0, 64'h0, 3'd3, 1'b0, 0, 1);
    // Invalid instruction beats dmem_error.
    do_reset("rst3");
    nop("boot3", 1'b0, 64'h1,   64'h0,   64'h0,  3'd1, 1'b1, 0, 0);
    step("pri2", 1'b0, 1'b0, 64'h1, 4'h1, 1'b0, 1'b0, 1'b1,
         64'h0, 64'h0, 3'd4, 1'b0, 0, 1);
    // Reset out of STOP.
    do_reset("rstS");
    nop("boot4", 1'b0, 64'h1,   64'h0,   64'h0,  3'd1, 1'b1, 0, 0);
    // dmem_error beats halt.
    step("pri3", 1'b0, 1'b0, 64'h1, 4'h0, 1'b1, 1'b0, 1'b1,
         64'h0, 64'h0, 3'd3, 1'b0, 0, 1);
    do_reset("rst5");
    nop("boot5", 1'b0, 64'h1,   64'h0,   64'h0,  3'd1, 1'b1, 0, 0);
    // Halt beats out-of-range next PC.
    step("pri4", 1'b0, 1'b0, 64'h2000, 4'h0, 1'b1, 1'b0, 1'b0,
         64'h0, 64'h0, 3'd2, 1'b0, 0, 1);

    // Reset mid-RUN at pc=0x40.
    do_reset("rst6");
    nop("boot6", 1'b0, 64'h40,  64'h0,   64'h0,  3'd1, 1'b1, 0, 0);
    nop("to40",  1'b0, 64'h40,  64'h40,  64'h0,  3'd1, 1'b1, 1, 1);
    do_reset("rstR");
    nop("boot7", 1'b0, 64'h1,   64'h0,   64'h0,  3'd1, 1'b1, 0, 0);

    // 17 commits: narrow counters wrap to 1, status stays AOK.
    for (int i = 1; i <= 17; i++)
      nop("wrap", 1'b0, 64'(i), 64'(i), 64'(i - 1), 3'd1, 1'b1, 32'(i), 32'(i));

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
